// File: rtl/muldiv_pkg.sv
// Shared types and opcode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

   localparam int MDU_XLEN = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } mdu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIN  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_t;

   function automatic logic is_signed_a(input mdu_op_t op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(input mdu_op_t op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_div(input mdu_op_t op);
      return op[2];
   endfunction

   function automatic logic is_rem(input mdu_op_t op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/muldiv_unit_iter_core.sv
// XLEN-step iterative datapath: shift-add multiply or restoring divide on unsigned magnitudes.
// Result sits in {o_hi, o_lo}: product halves for multiply, remainder/quotient for divide.
module mdu_iter_core
   import muldiv_pkg::*;
#(
   parameter int XLEN = MDU_XLEN
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic            i_load,
   input  logic            i_is_div,
   input  logic [XLEN-1:0] i_mag_a,
   input  logic [XLEN-1:0] i_mag_b,
   input  logic            i_run,
   output logic            o_last,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);

   localparam int CNT_W = $clog2(XLEN);

   logic            r_div;
   logic [XLEN-1:0] r_opnd;
   logic [XLEN-1:0] r_acc;
   logic [XLEN-1:0] r_lo;
   logic [CNT_W-1:0] r_cnt;

   logic [XLEN-1:0] w_addend;
   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_shift;
   logic [XLEN:0]   w_diff;

   // r_opnd is the multiplicand when multiplying and the divisor when dividing
   assign w_addend = r_lo[0] ? r_opnd : {XLEN{1'b0}};
   assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
   assign w_shift  = {r_acc, r_lo[XLEN-1]};
   assign w_diff   = w_shift - {1'b0, r_opnd};

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_div  <= 1'b0;
         r_opnd <= '0;
         r_acc  <= '0;
         r_lo   <= '0;
         r_cnt  <= '0;
      end else if (i_load) begin
         r_div <= i_is_div;
         r_acc <= '0;
         r_cnt <= '0;
         if (i_is_div) begin
            r_opnd <= i_mag_b;
            r_lo   <= i_mag_a;
         end else begin
            r_opnd <= i_mag_a;
            r_lo   <= i_mag_b;
         end
      end else if (i_run) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_div) begin
            if (!w_diff[XLEN]) begin
               r_acc <= w_diff[XLEN-1:0];
               r_lo  <= {r_lo[XLEN-2:0], 1'b1};
            end else begin
               r_acc <= w_shift[XLEN-1:0];
               r_lo  <= {r_lo[XLEN-2:0], 1'b0};
            end
         end else begin
            r_acc <= w_sum[XLEN:1];
            r_lo  <= {w_sum[0], r_lo[XLEN-1:1]};
         end
      end
   end

   assign o_last = (r_cnt == CNT_W'(XLEN - 1));
   assign o_hi   = r_acc;
   assign o_lo   = r_lo;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, operand capture, special cases, sign fix, outputs.
// Optional MULDIV_FAST_MUL_EN: multiplies resolve combinationally at the accept edge.
//
// state   | meaning
// IDLE    | waiting for MDUStart
// CALC    | iterative core stepping, XLEN edges
// FIN     | sign correction, result/rd registered
// DONE    | MDUDone pulse; may accept a new start
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = MDU_XLEN
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic            MDUStart,
   input  logic [2:0]      MDUFunct3,
   input  logic [XLEN-1:0] MDUA,
   input  logic [XLEN-1:0] MDUB,
   input  logic [4:0]      MDURd,
   output logic            MDUBusy,
   output logic            MDUDone,
   output logic [XLEN-1:0] MDUResult,
   output logic [4:0]      MDURdOut
);

   mdu_state_t r_state;
   mdu_state_t w_state_nxt;

   mdu_op_t         r_op;
   logic            r_neg_a;
   logic            r_neg_b;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_result;
   logic [4:0]      r_rd_out;

   mdu_op_t         w_op_in;
   logic            w_neg_a_in;
   logic            w_neg_b_in;
   logic [XLEN-1:0] w_mag_a;
   logic [XLEN-1:0] w_mag_b;
   logic            w_accept;
   logic            w_div_zero;
   logic            w_ovf;
   logic            w_fast;
   logic            w_short;
   logic [XLEN-1:0] w_short_res;
   logic            w_last;
   logic [XLEN-1:0] w_hi;
   logic [XLEN-1:0] w_lo;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_fix;
   logic [XLEN-1:0] w_quot_fix;
   logic [XLEN-1:0] w_rem_fix;
   logic [XLEN-1:0] w_fin_res;

   assign w_op_in    = mdu_op_t'(MDUFunct3);
   assign w_neg_a_in = is_signed_a(w_op_in) & MDUA[XLEN-1];
   assign w_neg_b_in = is_signed_b(w_op_in) & MDUB[XLEN-1];
   assign w_mag_a    = w_neg_a_in ? (~MDUA + 1'b1) : MDUA;
   assign w_mag_b    = w_neg_b_in ? (~MDUB + 1'b1) : MDUB;
   assign w_accept   = MDUStart & ((r_state == ST_IDLE) | (r_state == ST_DONE));

   assign w_div_zero = is_div(w_op_in) & (MDUB == '0);
   assign w_ovf      = is_div(w_op_in) & is_signed_a(w_op_in)
                     & (MDUA == {1'b1, {(XLEN-1){1'b0}}}) & (MDUB == {XLEN{1'b1}});

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] w_fast_prod;
   // sign/zero extension to 2*XLEN makes one unsigned multiply cover all four variants
   assign w_fast_prod = {{XLEN{w_neg_a_in}}, MDUA} * {{XLEN{w_neg_b_in}}, MDUB};
   assign w_fast      = ~is_div(w_op_in);
`else
   assign w_fast      = 1'b0;
`endif

   assign w_short = w_div_zero | w_ovf | w_fast;

   always_comb begin
      w_short_res = '0;
      if (is_rem(w_op_in)) begin
         w_short_res = w_div_zero ? MDUA : {XLEN{1'b0}};
      end else begin
         w_short_res = w_div_zero ? {XLEN{1'b1}} : MDUA;
      end
`ifdef MULDIV_FAST_MUL_EN
      if (!is_div(w_op_in)) begin
         w_short_res = (w_op_in == OP_MUL) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
      end
`endif
   end

   mdu_iter_core #(
      .XLEN (XLEN)
   ) u_core (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .i_load   (w_accept),
      .i_is_div (is_div(w_op_in)),
      .i_mag_a  (w_mag_a),
      .i_mag_b  (w_mag_b),
      .i_run    (r_state == ST_CALC),
      .o_last   (w_last),
      .o_hi     (w_hi),
      .o_lo     (w_lo)
   );

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = w_short ? ST_DONE : ST_CALC;
         ST_CALC: if (w_last)   w_state_nxt = ST_FIN;
         ST_FIN:                w_state_nxt = ST_DONE;
         ST_DONE: begin
            if (w_accept) w_state_nxt = w_short ? ST_DONE : ST_CALC;
            else          w_state_nxt = ST_IDLE;
         end
         default:               w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      MDUBusy = (r_state == ST_CALC) || (r_state == ST_FIN);
      MDUDone = (r_state == ST_DONE);
   end

   // remainder follows the dividend sign; product and quotient negate when signs differ
   assign w_prod     = {w_hi, w_lo};
   assign w_prod_fix = (r_neg_a ^ r_neg_b) ? (~w_prod + 1'b1) : w_prod;
   assign w_quot_fix = (r_neg_a ^ r_neg_b) ? (~w_lo + 1'b1) : w_lo;
   assign w_rem_fix  = r_neg_a ? (~w_hi + 1'b1) : w_hi;

   always_comb begin
      w_fin_res = '0;
      case (r_op)
         OP_MUL:                     w_fin_res = w_prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_fin_res = w_prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:            w_fin_res = w_quot_fix;
         OP_REM, OP_REMU:            w_fin_res = w_rem_fix;
         default:                    w_fin_res = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_op     <= OP_MUL;
         r_neg_a  <= 1'b0;
         r_neg_b  <= 1'b0;
         r_rd     <= '0;
         r_result <= '0;
         r_rd_out <= '0;
      end else if (w_accept) begin
         r_op    <= w_op_in;
         r_neg_a <= w_neg_a_in;
         r_neg_b <= w_neg_b_in;
         r_rd    <= MDURd;
         if (w_short) begin
            r_result <= w_short_res;
            r_rd_out <= MDURd;
         end
      end else if (r_state == ST_FIN) begin
         r_result <= w_fin_res;
         r_rd_out <= r_rd;
      end
   end

   assign MDUResult = r_result;
   assign MDURdOut  = r_rd_out;

endmodule
